// File: rtl/awmc_prog_ctrl_if.sv
// Control/status bundle for the washing-machine cycle sequencer.
// The abort input exists only when AWMC_ABORT_DRAIN_EN is defined.
interface awmc_prog_ctrl_if;
  logic       start;
  logic       pause;
  logic       lid;
`ifdef AWMC_ABORT_DRAIN_EN
  logic       abort;
`endif
  logic [2:0] stage;
  logic       paused;
  logic       lid_fault;
  logic [3:0] rinse_idx;
  logic       done;
  logic       input_valve;
  logic       output_drain;

`ifdef AWMC_ABORT_DRAIN_EN
  modport master (output start, pause, lid, abort,
                  input  stage, paused, lid_fault, rinse_idx, done, input_valve, output_drain);
  modport slave  (input  start, pause, lid, abort,
                  output stage, paused, lid_fault, rinse_idx, done, input_valve, output_drain);
`else
  modport master (output start, pause, lid,
                  input  stage, paused, lid_fault, rinse_idx, done, input_valve, output_drain);
  modport slave  (input  start, pause, lid,
                  output stage, paused, lid_fault, rinse_idx, done, input_valve, output_drain);
`endif
endinterface

// File: rtl/awmc_prog_ctrl.sv
// Washing-machine cycle sequencer: FILL -> WASH -> RINSE xN -> SPIN -> STOP, with pause/lid freeze.
// Optional feature macro: AWMC_ABORT_DRAIN_EN (abort input, drains for RINSE_TICKS then IDLE).
module awmc_prog_ctrl #(
  parameter int CNT_W        = 8,
  parameter int FILL_TICKS   = 10,
  parameter int WASH_TICKS   = 10,
  parameter int RINSE_CYCLES = 3,
  parameter int RINSE_TICKS  = 4,
  parameter int SPIN_TICKS   = 10
) (
  input  logic             clk,
  input  logic             reset,
  awmc_prog_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'b111, FILL = 3'b000, WASH = 3'b001,
    RINSE = 3'b010, SPIN = 3'b011, STOP = 3'b100
  } stage_e;

  localparam logic [CNT_W-1:0] FILL_END  = CNT_W'(FILL_TICKS - 1);
  localparam logic [CNT_W-1:0] WASH_END  = CNT_W'(WASH_TICKS - 1);
  localparam logic [CNT_W-1:0] RINSE_END = CNT_W'(RINSE_TICKS - 1);
  localparam logic [CNT_W-1:0] SPIN_END  = CNT_W'(SPIN_TICKS - 1);
  localparam logic [3:0]       RIDX_LAST = 4'(RINSE_CYCLES - 1);

  stage_e           st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, tc;
  logic [3:0]       ridx_q, ridx_d;
  logic             half_q, half_d;    // 0: drain half of a rinse, 1: refill half
  logic             abrt_q, abrt_d;    // STOP is an abort drain rather than a normal end
  logic             paused_q, paused_d, lidf_q, lidf_d, done_q, done_d;
  logic             valve_q, valve_d, drain_q, drain_d;
  logic             abort_req;

`ifdef AWMC_ABORT_DRAIN_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    case (st_q)
      FILL:    tc = FILL_END;
      WASH:    tc = WASH_END;
      SPIN:    tc = SPIN_END;
      default: tc = RINSE_END;
    endcase
  end

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    ridx_d   = ridx_q;
    half_d   = half_q;
    abrt_d   = abrt_q;
    done_d   = done_q;
    paused_d = 1'b0;
    lidf_d   = 1'b0;
    case (st_q)
      IDLE: begin
        if (bus.start && !bus.pause) begin
          st_d   = FILL;
          cnt_d  = '0;
          done_d = 1'b0;
        end
      end
      STOP: begin
        if (abrt_q && cnt_q != RINSE_END) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          st_d   = IDLE;
          cnt_d  = '0;
          done_d = !abrt_q;
          abrt_d = 1'b0;
        end
      end
      default: begin
        // Freezing simply holds all state; the release edge then sequences normally.
        if (bus.pause) begin
          paused_d = 1'b1;
        end else if (abort_req) begin
          st_d   = STOP;
          cnt_d  = '0;
          ridx_d = '0;
          half_d = 1'b0;
          abrt_d = 1'b1;
        end else if (bus.lid && (st_q != FILL || cnt_q == FILL_END)) begin
          lidf_d = 1'b1;
        end else if (cnt_q != tc) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          case (st_q)
            FILL: st_d = WASH;
            WASH: begin
              st_d   = RINSE;
              ridx_d = '0;
              half_d = 1'b0;
            end
            RINSE: begin
              if (!half_q) begin
                half_d = 1'b1;
              end else if (ridx_q != RIDX_LAST) begin
                ridx_d = ridx_q + 4'd1;
                half_d = 1'b0;
              end else begin
                st_d   = SPIN;
                ridx_d = '0;
                half_d = 1'b0;
              end
            end
            default: st_d = STOP;
          endcase
        end
      end
    endcase
    valve_d = !paused_d && !lidf_d && (st_d == FILL || (st_d == RINSE && half_d));
    drain_d = !paused_d && !lidf_d &&
              ((st_d == RINSE && !half_d) || st_d == SPIN || (st_d == STOP && abrt_d));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q     <= IDLE;
      cnt_q    <= '0;
      ridx_q   <= '0;
      half_q   <= 1'b0;
      abrt_q   <= 1'b0;
      paused_q <= 1'b0;
      lidf_q   <= 1'b0;
      done_q   <= 1'b0;
      valve_q  <= 1'b0;
      drain_q  <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      ridx_q   <= ridx_d;
      half_q   <= half_d;
      abrt_q   <= abrt_d;
      paused_q <= paused_d;
      lidf_q   <= lidf_d;
      done_q   <= done_d;
      valve_q  <= valve_d;
      drain_q  <= drain_d;
    end
  end

  assign bus.stage        = st_q;
  assign bus.paused       = paused_q;
  assign bus.lid_fault    = lidf_q;
  assign bus.rinse_idx    = ridx_q;
  assign bus.done         = done_q;
  assign bus.input_valve  = valve_q;
  assign bus.output_drain = drain_q;
endmodule

// File: tb/tb_awmc_prog_ctrl.sv
// Bench for awmc_prog_ctrl: directed timing scenarios plus random pause/lid/start/reset traffic,
// checked every cycle against a flattened step-schedule model of the wash program.
module tb_awmc_prog_ctrl;
  localparam int FT = 10, WT = 10, RC = 3, RT = 4, ST = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  awmc_prog_ctrl_if bus ();

  awmc_prog_ctrl #(
    .CNT_W(8), .FILL_TICKS(FT), .WASH_TICKS(WT), .RINSE_CYCLES(RC),
    .RINSE_TICKS(RT), .SPIN_TICKS(ST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int stg; int ridx; bit v; bit d; bit ls;
  } step_t;
  step_t sched[$];

  int n_chk = 0, n_fail = 0;
  bit m_act, m_paused, m_lidf, m_done;
  int m_pos, m_abl;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Whole program unrolled into one entry per displayed cycle.
  task automatic build_sched();
    step_t s;
    for (int i = 0; i < FT; i++) begin s = '{0, 0, 1'b1, 1'b0, (i == FT-1)}; sched.push_back(s); end
    for (int i = 0; i < WT; i++) begin s = '{1, 0, 1'b0, 1'b0, 1'b1}; sched.push_back(s); end
    for (int r = 0; r < RC; r++) begin
      for (int i = 0; i < RT; i++) begin s = '{2, r, 1'b0, 1'b1, 1'b1}; sched.push_back(s); end
      for (int i = 0; i < RT; i++) begin s = '{2, r, 1'b1, 1'b0, 1'b1}; sched.push_back(s); end
    end
    for (int i = 0; i < ST; i++) begin s = '{3, 0, 1'b0, 1'b1, 1'b1}; sched.push_back(s); end
    s = '{4, 0, 1'b0, 1'b0, 1'b0};
    sched.push_back(s);
  endtask

  task automatic model_reset();
    m_act = 0; m_paused = 0; m_lidf = 0; m_done = 0; m_pos = 0; m_abl = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit l, input bit a);
    m_paused = 0;
    m_lidf   = 0;
    if (!m_act) begin
      if (s && !p) begin m_act = 1; m_pos = 0; m_done = 0; end
    end else if (m_abl > 0) begin
      m_abl--;
      if (m_abl == 0) m_act = 0;
    end else if (sched[m_pos].stg == 4) begin
      m_act = 0; m_done = 1;
    end else if (p)                       m_paused = 1;
    else if (a)                           m_abl = RT;
    else if (l && sched[m_pos].ls)        m_lidf = 1;
    else                                  m_pos++;
  endtask

  task automatic compare();
    int es, er; bit ev, ed;
    if (!m_act) begin
      es = 7; er = 0; ev = 0; ed = 0;
    end else if (m_abl > 0) begin
      es = 4; er = 0; ev = 0; ed = 1;
    end else begin
      es = sched[m_pos].stg; er = sched[m_pos].ridx;
      ev = sched[m_pos].v && !m_paused && !m_lidf;
      ed = sched[m_pos].d && !m_paused && !m_lidf;
    end
    chk("stage", int'(bus.stage), es);
    chk("rinse_idx", int'(bus.rinse_idx), er);
    chk("input_valve", int'(bus.input_valve), int'(ev));
    chk("output_drain", int'(bus.output_drain), int'(ed));
    chk("paused", int'(bus.paused), int'(m_paused));
    chk("lid_fault", int'(bus.lid_fault), int'(m_lidf));
    chk("done", int'(bus.done), int'(m_done));
    chk("valve_excl", int'(bus.input_valve & bus.output_drain), 0);
  endtask

  task automatic cycle(input bit s, input bit p, input bit l, input bit a);
    bus.start = s; bus.pause = p; bus.lid = l;
`ifdef AWMC_ABORT_DRAIN_EN
    bus.abort = a;
`endif
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step(s, p, l, a);
    #1;
  endtask

  task automatic run_to_done(output int lat);
    lat = 0;
    while (!bus.done && lat < 300) begin
      cycle(0, 0, 0, 0);
      lat++;
    end
  endtask

  // Reset lands between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  int lat;
  bit rp, rl;

  initial begin
    build_sched();
    model_reset();
    reset = 1'b1;
    bus.start = 0; bus.pause = 0; bus.lid = 0;
`ifdef AWMC_ABORT_DRAIN_EN
    bus.abort = 0;
`endif
    #12;
    compare();
    @(posedge clk);
    #1 reset = 1'b0;

    // Nominal cycle: done 55 edges after the start edge.
    cycle(1, 0, 0, 0);
    run_to_done(lat);
    chk("lat_nominal", lat, 55);

    // Pause 5 cycles at WASH count 3 shifts completion by exactly 5.
    cycle(1, 0, 0, 0);
    repeat (13) cycle(0, 0, 0, 0);
    repeat (5) cycle(0, 1, 0, 0);
    run_to_done(lat);
    chk("lat_pause", 13 + 5 + lat, 60);

    // Lid open through end of FILL: held 3 extra cycles with valve off.
    cycle(1, 0, 1, 0);
    repeat (12) cycle(0, 0, 1, 0);
    run_to_done(lat);
    chk("lat_fill_lid", 12 + lat, 58);

    // Lid open 7 cycles at SPIN count 6.
    cycle(1, 0, 0, 0);
    repeat (50) cycle(0, 0, 0, 0);
    repeat (7) cycle(0, 0, 1, 0);
    run_to_done(lat);
    chk("lat_spin_lid", 57 + lat, 62);

    // Async reset mid-RINSE, then start blocked by pause in IDLE.
    cycle(1, 0, 0, 0);
    repeat (25) cycle(0, 0, 0, 0);
    async_reset();
    repeat (3) cycle(1, 1, 0, 0);
    chk("idle_blocked", int'(bus.stage), 7);

`ifdef AWMC_ABORT_DRAIN_EN
    cycle(1, 0, 0, 0);
    repeat (12) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    lat = 0;
    while (bus.stage != 3'b111 && lat < 50) begin cycle(0, 0, 0, 0); lat++; end
    chk("abort_drain_len", lat, RT);
    chk("abort_done", int'(bus.done), 0);
`endif

    // Random traffic: level pause/lid with sticky bursts, start pulses, rare resets.
    rp = 0; rl = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 6) rp = ~rp;
      if ($urandom_range(0, 99) < 8) rl = ~rl;
      if ($urandom_range(0, 999) < 3) async_reset();
`ifdef AWMC_ABORT_DRAIN_EN
      cycle($urandom_range(0, 99) < 10, rp, rl, $urandom_range(0, 199) == 0);
`else
      cycle($urandom_range(0, 99) < 10, rp, rl, 1'b0);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
